pll_lock_supervisor: RTL and testbench

//  Drives a PLL wrapper's reset input and consumes its async 'locked' output.

---
 rtl/pll_sup_pkg.sv | 22 ++
 rtl/pll_lock_supervisor_if.sv | 25 ++
 rtl/sync_bit.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 114 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/pll_sup_pkg.sv
// Shared state encodings and sizing helpers for the PLL lock supervisor.
// Everything here is elaborated at compile time; nothing is clocked.
package pll_sup_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STABLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    // Cycle-counter width: enough to hold the largest terminal count, never zero.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-facing and system-facing signals of the lock supervisor.
// master is the supervisor side; slave is the PLL/system side.
interface pll_lock_supervisor_if
    import pll_sup_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic               locked;
    logic               pll_rst;
    logic               sys_rst;
    logic               lock_ok;
    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   retry_cnt;
    logic [CNT_W-1:0]   lost_cnt;

    modport master (
        input  locked,
        output pll_rst, sys_rst, lock_ok, state, retry_cnt, lost_cnt
    );

    modport slave (
        output locked,
        input  pll_rst, sys_rst, lock_ok, state, retry_cnt, lost_cnt
    );
endinterface

// File: rtl/sync_bit.sv
// Single-bit synchronizer: STAGES-deep flop chain with synchronous clear.
// Latency is STAGES clock edges; no backpressure.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for lock with timeout, and releases sys_rst only after lock is stable.
// Lock rise to sys_rst fall: SYNC_STAGES+1+STABLE_CYCLES edges; lock loss in RUN: SYNC_STAGES+1 edges.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_lock_supervisor_if.master bus
);
    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CW-1:0]    RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0]    TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]    STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CNT_W-1:0] EVT_ONE  = CNT_W'(1);

    logic             w_locked_s;
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_lock_ok;
    logic [CNT_W-1:0] r_retry;
    logic [CNT_W-1:0] r_lost;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clk (refclk),
        .i_rst (rst),
        .i_d   (bus.locked),
        .o_q   (w_locked_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state   <= ST_RESET;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_lock_ok <= 1'b0;
            r_retry   <= '0;
            r_lost    <= '0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    if (r_cnt == RST_LAST) begin
                        r_state   <= ST_WAIT;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (w_locked_s) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TMO_LAST) begin
                        r_state   <= ST_RESET;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        if (!(&r_retry)) r_retry <= r_retry + EVT_ONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                // A dropout here is treated as a glitch: retry silently, no event counted.
                ST_STABLE: begin
                    if (!w_locked_s) begin
                        r_state   <= ST_RESET;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                    end else if (r_cnt == STB_LAST) begin
                        r_state   <= ST_RUN;
                        r_cnt     <= '0;
                        r_sys_rst <= 1'b0;
                        r_lock_ok <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!w_locked_s) begin
                        r_state   <= ST_RESET;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        r_sys_rst <= 1'b1;
                        r_lock_ok <= 1'b0;
                        if (!(&r_lost)) r_lost <= r_lost + EVT_ONE;
                    end
                end
                default: begin
                    r_state   <= ST_RESET;
                    r_cnt     <= '0;
                    r_pll_rst <= 1'b1;
                    r_sys_rst <= 1'b1;
                    r_lock_ok <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst   = r_pll_rst;
    assign bus.sys_rst   = r_sys_rst;
    assign bus.lock_ok   = r_lock_ok;
    assign bus.state     = r_state;
    assign bus.retry_cnt = r_retry;
    assign bus.lost_cnt  = r_lost;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;
    logic refclk;
    logic rst;
    int   checks;
    int   errors;

    pll_lock_supervisor_if #(.CNT_W(4)) bus ();

    pll_lock_supervisor #(
        .SYNC_STAGES    (2),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .CNT_W          (4)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.locked = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
        checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b expected 1", bus.pll_rst); end
        checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL reset_sys_rst: got %b expected 1", bus.sys_rst); end
        checks++; if (bus.lock_ok !== 1'b0) begin errors++; $display("FAIL reset_lock_ok: got %b expected 0", bus.lock_ok); end
        checks++; if (bus.retry_cnt !== 4'd0) begin errors++; $display("FAIL reset_retry: got %0d expected 0", bus.retry_cnt); end
        checks++; if (bus.lost_cnt !== 4'd0) begin errors++; $display("FAIL reset_lost: got %0d expected 0", bus.lost_cnt); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL pll_rst_pulse cycle %0d: got %b expected 1", i, bus.pll_rst); end
        end
        tick();
        checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL pll_rst_end: got %b expected 0", bus.pll_rst); end
        checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL wait_sys_rst: got %b expected 1", bus.sys_rst); end
        checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL wait_state: got %0d expected 1", bus.state); end
    endtask

    task automatic test_lock();
        repeat (4) tick();
        bus.locked = 1'b1;
        repeat (2) tick();
        checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL lock_sync_delay: got %0d expected 1", bus.state); end
        tick();
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL lock_stable_entry: got %0d expected 2", bus.state); end
        repeat (7) tick();
        checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL lock_edge10_sys_rst: got %b expected 1", bus.sys_rst); end
        tick();
        checks++; if (bus.sys_rst !== 1'b0) begin errors++; $display("FAIL lock_edge11_sys_rst: got %b expected 0", bus.sys_rst); end
        checks++; if (bus.lock_ok !== 1'b1) begin errors++; $display("FAIL lock_lock_ok: got %b expected 1", bus.lock_ok); end
        checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL lock_run_state: got %0d expected 3", bus.state); end
        checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL lock_pll_rst: got %b expected 0", bus.pll_rst); end
    endtask

    task automatic test_run_loss();
        bus.locked = 1'b0;
        repeat (2) tick();
        checks++; if (bus.sys_rst !== 1'b0) begin errors++; $display("FAIL loss_early_sys_rst: got %b expected 0", bus.sys_rst); end
        tick();
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL loss_state: got %0d expected 0", bus.state); end
        checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL loss_sys_rst: got %b expected 1", bus.sys_rst); end
        checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL loss_pll_rst: got %b expected 1", bus.pll_rst); end
        checks++; if (bus.lock_ok !== 1'b0) begin errors++; $display("FAIL loss_lock_ok: got %b expected 0", bus.lock_ok); end
        checks++; if (bus.lost_cnt !== 4'd1) begin errors++; $display("FAIL loss_lost_cnt: got %0d expected 1", bus.lost_cnt); end
        checks++; if (bus.retry_cnt !== 4'd0) begin errors++; $display("FAIL loss_retry_cnt: got %0d expected 0", bus.retry_cnt); end
        bus.locked = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL relock_full_pulse cycle %0d: got %b expected 1", i, bus.pll_rst); end
        end
        repeat (9) tick();
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL relock_stable: got %0d expected 2", bus.state); end
        tick();
        checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL relock_run: got %0d expected 3", bus.state); end
        checks++; if (bus.lost_cnt !== 4'd1) begin errors++; $display("FAIL relock_lost_cnt: got %0d expected 1", bus.lost_cnt); end
    endtask

    task automatic test_stable_glitch();
        bus.locked = 1'b0;
        repeat (3) tick();
        checks++; if (bus.lost_cnt !== 4'd2) begin errors++; $display("FAIL glitch_pre_lost: got %0d expected 2", bus.lost_cnt); end
        bus.locked = 1'b1;
        repeat (6) tick();
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL glitch_in_stable: got %0d expected 2", bus.state); end
        bus.locked = 1'b0;
        tick();
        bus.locked = 1'b1;
        tick();
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL glitch_sync_delay: got %0d expected 2", bus.state); end
        checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL glitch_sys_rst_mid: got %b expected 1", bus.sys_rst); end
        tick();
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL glitch_state: got %0d expected 0", bus.state); end
        checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL glitch_pll_rst: got %b expected 1", bus.pll_rst); end
        checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL glitch_sys_rst: got %b expected 1", bus.sys_rst); end
        checks++; if (bus.lost_cnt !== 4'd2) begin errors++; $display("FAIL glitch_lost_cnt: got %0d expected 2", bus.lost_cnt); end
        checks++; if (bus.retry_cnt !== 4'd0) begin errors++; $display("FAIL glitch_retry_cnt: got %0d expected 0", bus.retry_cnt); end
    endtask

    task automatic test_retry();
        logic [3:0] exp_prev;
        logic [3:0] exp_now;
        bus.locked = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            exp_prev = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
            exp_now  = (k > 15) ? 4'd15 : 4'(k);
            repeat (23) tick();
            checks++; if (bus.state !== 2'd1 || bus.retry_cnt !== exp_prev) begin
                errors++; $display("FAIL retry_before_%0d: got state %0d retry %0d expected state 1 retry %0d", k, bus.state, bus.retry_cnt, exp_prev);
            end
            tick();
            checks++; if (bus.state !== 2'd0 || bus.pll_rst !== 1'b1 || bus.retry_cnt !== exp_now) begin
                errors++; $display("FAIL retry_timeout_%0d: got state %0d pll_rst %b retry %0d expected state 0 pll_rst 1 retry %0d", k, bus.state, bus.pll_rst, bus.retry_cnt, exp_now);
            end
        end
        checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL retry_sys_rst: got %b expected 1", bus.sys_rst); end
    endtask

    task automatic test_rst_in_run();
        int n;
        bus.locked = 1'b1;
        n = 0;
        while (bus.state !== 2'd3 && n < 60) begin
            tick();
            n++;
        end
        checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL rst_run_reach: got state %0d expected 3 within 60 cycles", bus.state); end
        checks++; if (bus.retry_cnt !== 4'd15) begin errors++; $display("FAIL rst_run_retry_hold: got %0d expected 15", bus.retry_cnt); end
        rst = 1'b1;
        tick();
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL rst_run_state: got %0d expected 0", bus.state); end
        checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL rst_run_pll_rst: got %b expected 1", bus.pll_rst); end
        checks++; if (bus.sys_rst !== 1'b1) begin errors++; $display("FAIL rst_run_sys_rst: got %b expected 1", bus.sys_rst); end
        checks++; if (bus.lock_ok !== 1'b0) begin errors++; $display("FAIL rst_run_lock_ok: got %b expected 0", bus.lock_ok); end
        checks++; if (bus.retry_cnt !== 4'd0) begin errors++; $display("FAIL rst_run_retry: got %0d expected 0", bus.retry_cnt); end
        checks++; if (bus.lost_cnt !== 4'd0) begin errors++; $display("FAIL rst_run_lost: got %0d expected 0", bus.lost_cnt); end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.locked = 1'b0;
        test_reset();
        test_lock();
        test_run_loss();
        test_stable_glitch();
        test_retry();
        test_rst_in_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
